// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction-memory bootstrap loader for the RV32I core
//
// Purpose:
//   Accepts a program image as a valid/ready word stream and writes each word
//   into instruction memory at BASE_ADDR + n*ADDR_STRIDE. The CPU is held in
//   reset while loading and for RELEASE_CYCLES after the last write. Then it
//   is released. A new load may be started from IDLE, RUN or ERROR. An image
//   longer than DEPTH words stops the load in ERROR.
//
// Ports:
//   clk          in   clock, all state on rising edge
//   r            in   asynchronous active-high reset
//   start        in   begin a load (honoured in IDLE, RUN, ERROR only)
//   s_valid      in   stream word valid
//   s_data       in   stream word
//   s_last       in   final word of the image
//   s_ready      out  loader accepts a word (high exactly in LOAD)
//   i_mem_addr   out  instruction memory write address (byte address)
//   i_mem_data   out  instruction memory write data
//   i_mem_write  out  one-cycle write strobe per accepted word
//   cpu_r        out  CPU reset, low only in RUN
//   done         out  image loaded and CPU running
//   err          out  image exceeded DEPTH words
//   word_count   out  words written in the current image

module imem_loader #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned ADDR_STRIDE    = 4,
  parameter int unsigned RELEASE_CYCLES = 4,
  localparam int unsigned CW            = $clog2(DEPTH + 1),
  localparam int unsigned RW            = $clog2(RELEASE_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  r,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] i_mem_addr,
  output logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  i_mem_write,
  output logic                  cpu_r,
  output logic                  done,
  output logic                  err,
  output logic [CW-1:0]         word_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  // Registered state and outputs
  state_t                r_state;
  logic                  r_mem_write;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_cpu_r;
  logic                  r_done;
  logic                  r_err;
  logic [CW-1:0]         r_word_count;
  logic [RW-1:0]         r_rel_cnt;

  // Next-state values
  state_t                w_state_nxt;
  logic                  w_mem_write_nxt;
  logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0] w_mem_data_nxt;
  logic                  w_cpu_r_nxt;
  logic                  w_done_nxt;
  logic                  w_err_nxt;
  logic [CW-1:0]         w_word_count_nxt;
  logic [RW-1:0]         w_rel_cnt_nxt;

  logic                  w_full;
  logic [ADDR_WIDTH-1:0] w_wr_addr;

  // The image is full once DEPTH words have been written; a further beat is
  // an overflow rather than a write.
  assign w_full    = (r_word_count == CW'(DEPTH));

  // Address of the next word, derived from the count so it cannot drift from
  // word_count; wraps naturally at ADDR_WIDTH.
  assign w_wr_addr = ADDR_WIDTH'(BASE_ADDR)
                   + ADDR_WIDTH'(r_word_count) * ADDR_WIDTH'(ADDR_STRIDE);

  always_comb begin
    w_state_nxt      = r_state;
    w_mem_write_nxt  = 1'b0;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_data_nxt   = r_mem_data;
    w_cpu_r_nxt      = r_cpu_r;
    w_done_nxt       = r_done;
    w_err_nxt        = r_err;
    w_word_count_nxt = r_word_count;
    w_rel_cnt_nxt    = r_rel_cnt;

    case (r_state)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start) begin
          w_state_nxt      = ST_LOAD;
          w_word_count_nxt = '0;
          w_done_nxt       = 1'b0;
          w_err_nxt        = 1'b0;
          w_cpu_r_nxt      = 1'b1;
        end
      end

      ST_LOAD: begin
        // s_ready is high for the whole of LOAD, so s_valid alone is a handshake
        if (s_valid) begin
          if (w_full) begin
            // Overflow: drop the beat, s_last is irrelevant here
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_ERROR;
          end else begin
            w_mem_write_nxt  = 1'b1;
            w_mem_addr_nxt   = w_wr_addr;
            w_mem_data_nxt   = s_data;
            w_word_count_nxt = r_word_count + CW'(1);
            if (s_last) begin
              w_state_nxt   = ST_RELEASE;
              w_rel_cnt_nxt = RW'(RELEASE_CYCLES);
            end
          end
        end
      end

      ST_RELEASE: begin
        // Counter loaded on the last-beat edge; leaving when it shows 1 puts
        // the CPU release exactly RELEASE_CYCLES edges after that beat.
        if (r_rel_cnt <= RW'(1)) begin
          w_state_nxt   = ST_RUN;
          w_cpu_r_nxt   = 1'b0;
          w_done_nxt    = 1'b1;
          w_rel_cnt_nxt = '0;
        end else begin
          w_rel_cnt_nxt = r_rel_cnt - RW'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_state      <= ST_IDLE;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= ADDR_WIDTH'(BASE_ADDR);
      r_mem_data   <= '0;
      r_cpu_r      <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_word_count <= '0;
      r_rel_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_data   <= w_mem_data_nxt;
      r_cpu_r      <= w_cpu_r_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_word_count <= w_word_count_nxt;
      r_rel_cnt    <= w_rel_cnt_nxt;
    end
  end

  assign s_ready     = (r_state == ST_LOAD);
  assign i_mem_write = r_mem_write;
  assign i_mem_addr  = r_mem_addr;
  assign i_mem_data  = r_mem_data;
  assign cpu_r       = r_cpu_r;
  assign done        = r_done;
  assign err         = r_err;
  assign word_count  = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader

module tb_imem_loader;

  logic        clk;
  logic        r;
  logic        start;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;

  // Instance A: DEPTH=4, BASE_ADDR=0
  logic        a_s_ready, a_wr, a_cpu_r, a_done, a_err;
  logic [31:0] a_addr, a_data;
  logic [2:0]  a_wc;

  // Instance B: DEPTH=1024, BASE_ADDR=0x100
  logic        b_s_ready, b_wr, b_cpu_r, b_done, b_err;
  logic [31:0] b_addr, b_data;
  logic [10:0] b_wc;

  int checks = 0;
  int errors = 0;

  imem_loader #(.DEPTH(4), .BASE_ADDR(0)) u_a (
    .clk(clk), .r(r), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(a_s_ready), .i_mem_addr(a_addr),
    .i_mem_data(a_data), .i_mem_write(a_wr), .cpu_r(a_cpu_r),
    .done(a_done), .err(a_err), .word_count(a_wc)
  );

  imem_loader #(.DEPTH(1024), .BASE_ADDR(32'h100)) u_b (
    .clk(clk), .r(r), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(b_s_ready), .i_mem_addr(b_addr),
    .i_mem_data(b_data), .i_mem_write(b_wr), .cpu_r(b_cpu_r),
    .done(b_done), .err(b_err), .word_count(b_wc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [31:0] d, input logic l);
    s_valid = v;
    s_data  = d;
    s_last  = l;
  endtask

  initial begin
    r = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    #1;
    // Reset values, before any clock edge
    chk("rst_s_ready", a_s_ready, 0);
    chk("rst_write",   a_wr,      0);
    chk("rst_addr_a",  a_addr,    0);
    chk("rst_addr_b",  b_addr,    32'h100);
    chk("rst_data",    a_data,    0);
    chk("rst_cpu_r",   a_cpu_r,   1);
    chk("rst_done",    a_done,    0);
    chk("rst_err",     a_err,     0);
    chk("rst_wc",      a_wc,      0);
    step(); step();
    r = 1'b0;
    step();
    chk("idle_s_ready", a_s_ready, 0);

    // ---- Default 3-word image ----
    start = 1'b1;
    step();
    chk("t1_s_ready", a_s_ready, 1);
    chk("t1_wr0_none", a_wr, 0);
    start = 1'b0;
    beat(1, 32'h00500093, 0);
    step();
    chk("t1_w0_wr",   a_wr,   1);
    chk("t1_w0_addr", a_addr, 32'h0);
    chk("t1_w0_data", a_data, 32'h00500093);
    chk("t1_w0_wc",   a_wc,   1);
    beat(1, 32'h00100113, 0);
    step();
    chk("t1_w1_wr",   a_wr,   1);
    chk("t1_w1_addr", a_addr, 32'h4);
    chk("t1_w1_data", a_data, 32'h00100113);
    beat(1, 32'h002081B3, 1);
    step();  // edge N: last accepted
    chk("t1_w2_wr",     a_wr,      1);
    chk("t1_w2_addr",   a_addr,    32'h8);
    chk("t1_w2_data",   a_data,    32'h002081B3);
    chk("t1_w2_addr_b", b_addr,    32'h108);
    chk("t1_wc",        a_wc,      3);
    chk("t1_rel_ready", a_s_ready, 0);
    chk("t1_rel_cpu_r", a_cpu_r,   1);
    beat(0, 32'hDEADBEEF, 0);
    step();  // N+1
    chk("t1_n1_wr",    a_wr,    0);
    chk("t1_n1_addr",  a_addr,  32'h8);
    chk("t1_n1_data",  a_data,  32'h002081B3);
    chk("t1_n1_cpu_r", a_cpu_r, 1);
    step();  // N+2
    step();  // N+3
    chk("t1_n3_cpu_r", a_cpu_r, 1);
    chk("t1_n3_done",  a_done,  0);
    step();  // N+4
    chk("t1_n4_cpu_r", a_cpu_r, 0);
    chk("t1_n4_done",  a_done,  1);
    step();
    chk("t1_run_hold", a_cpu_r, 0);

    // ---- Reload from RUN, with start pulsed in LOAD and RELEASE ----
    start = 1'b1;
    step();
    chk("t5_cpu_r",   a_cpu_r,   1);
    chk("t5_done",    a_done,    0);
    chk("t5_wc",      a_wc,      0);
    chk("t5_s_ready", a_s_ready, 1);
    beat(1, 32'hAAAA0001, 0);  // start still high during LOAD
    step();
    chk("t5_w0_wr",   a_wr,      1);
    chk("t5_w0_addr", a_addr,    32'h0);
    chk("t5_w0_wc",   a_wc,      1);
    chk("t5_w0_rdy",  a_s_ready, 1);
    start = 1'b0;
    beat(1, 32'hAAAA0002, 1);
    step();  // edge N
    chk("t5_w1_addr", a_addr, 32'h4);
    chk("t5_w1_data", a_data, 32'hAAAA0002);
    chk("t5_w1_wc",   a_wc,   2);
    beat(0, 32'h0, 0);
    start = 1'b1;  // pulse in RELEASE
    step();  // N+1
    chk("t5_n1_wr",    a_wr,      0);
    chk("t5_n1_ready", a_s_ready, 0);
    start = 1'b0;
    step();  // N+2
    step();  // N+3
    chk("t5_n3_cpu_r", a_cpu_r, 1);
    step();  // N+4
    chk("t5_n4_cpu_r", a_cpu_r, 0);
    chk("t5_n4_done",  a_done,  1);

    // ---- Gapped stream on instance B (BASE_ADDR=0x100) ----
    start = 1'b1;
    step();
    start = 1'b0;
    beat(1, 32'h11111111, 0);
    step();
    chk("t2_c1_wr",   b_wr,   1);
    chk("t2_c1_addr", b_addr, 32'h100);
    beat(0, 32'h0, 0);
    step();
    chk("t2_c2_wr", b_wr, 0);
    step();
    chk("t2_c3_wr", b_wr, 0);
    beat(1, 32'h22222222, 0);
    step();
    chk("t2_c4_wr",   b_wr,   1);
    chk("t2_c4_addr", b_addr, 32'h104);
    beat(0, 32'h0, 0);
    step();
    chk("t2_c5_wr",   b_wr,   0);
    chk("t2_c5_addr", b_addr, 32'h104);
    beat(1, 32'h33333333, 1);
    step();
    chk("t2_c6_wr",   b_wr,   1);
    chk("t2_c6_addr", b_addr, 32'h108);
    chk("t2_c6_data", b_data, 32'h33333333);
    chk("t2_wc",      b_wc,   3);
    beat(0, 32'h0, 0);
    step();
    chk("t2_c7_wr", b_wr, 0);
    step(); step(); step();
    chk("t2_done", b_done, 1);
    chk("a_run_done", a_done, 1);

    // ---- Overflow on instance A (DEPTH=4) ----
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(1, 32'h10 + i, 0);
      step();
      chk("t3_wr",   a_wr,   1);
      chk("t3_addr", a_addr, 32'(4 * i));
      chk("t3_wc",   a_wc,   64'(i + 1));
    end
    beat(1, 32'h14, 0);
    step();
    chk("t3_ov_wr",    a_wr,      0);
    chk("t3_ov_err",   a_err,     1);
    chk("t3_ov_rdy",   a_s_ready, 0);
    chk("t3_ov_cpu_r", a_cpu_r,   1);
    chk("t3_ov_wc",    a_wc,      4);
    chk("t3_ov_addr",  a_addr,    32'hC);
    beat(0, 32'h0, 0);
    step();
    chk("t3_hold_err", a_err, 1);
    chk("t3_hold_wr",  a_wr,  0);
    start = 1'b1;
    step();
    chk("t3_re_err", a_err,     0);
    chk("t3_re_rdy", a_s_ready, 1);
    chk("t3_re_wc",  a_wc,      0);
    start = 1'b0;
    beat(1, 32'h00000077, 1);  // one-word image
    step();
    chk("t3_one_wr",   a_wr,      1);
    chk("t3_one_addr", a_addr,    32'h0);
    chk("t3_one_wc",   a_wc,      1);
    chk("t3_one_rdy",  a_s_ready, 0);
    beat(0, 32'h0, 0);
    step(); step(); step();
    chk("t3_one_n3", a_cpu_r, 1);
    step();
    chk("t3_one_n4", a_cpu_r, 0);

    // ---- Asynchronous reset after 2 of 5 words ----
    start = 1'b1;
    step();
    start = 1'b0;
    beat(1, 32'hC0DE0000, 0);
    step();
    beat(1, 32'hC0DE0001, 0);
    step();
    chk("t4_wc2",   a_wc,   2);
    chk("t4_addr2", a_addr, 32'h4);
    beat(1, 32'hC0DE0002, 0);
    #2;
    r = 1'b1;
    #1;  // mid-cycle, no clock edge since reset rose
    chk("t4_ar_wr",    a_wr,      0);
    chk("t4_ar_addr",  a_addr,    32'h0);
    chk("t4_ar_addrb", b_addr,    32'h100);
    chk("t4_ar_data",  a_data,    0);
    chk("t4_ar_wc",    a_wc,      0);
    chk("t4_ar_rdy",   a_s_ready, 0);
    chk("t4_ar_cpu_r", a_cpu_r,   1);
    chk("t4_ar_done",  a_done,    0);
    chk("t4_ar_err",   a_err,     0);
    step();
    chk("t4_hold_wr", a_wr, 0);
    r = 1'b0;
    step();
    chk("t4_idle_wr", a_wr, 0);
    chk("t4_idle_wc", a_wc, 0);
    start = 1'b1;
    beat(0, 32'h0, 0);
    step();
    start = 1'b0;
    beat(1, 32'h00000055, 1);
    step();
    chk("t4_new_wr",   a_wr,   1);
    chk("t4_new_addr", a_addr, 32'h0);
    chk("t4_new_data", a_data, 32'h55);
    chk("t4_new_wc",   a_wc,   1);
    beat(0, 32'h0, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
